pe_bus_responder: RTL and testbench

Responder end of the processing-element bus: arbitrates `bus_request` from NUM_PE processing elements, returns a one-hot `grant`, and services the granted PE's commands. It owns the shared 32×32 local register file (rs1/rs2 reads, rd writes) and a word-addressed global data memory (mem_read/mem_write with `mem_ackBus`). It sits between the PE array and the controller, driving the Amux/Bmux/memData return path every PE bus interface consumes.

---
 rtl/pe_bus_pkg.sv | 35 +++
 rtl/pe_bus_responder_arb.sv | 33 +++
 rtl/pe_bus_responder.sv | 241 ++++++++++++++++++++++++
 tb/tb_pe_bus_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_bus_pkg.sv
// Shared types and helpers for the PE bus responder: FSM states, register-file
// geometry and the bypassed register read used on the Amux/Bmux return path.
package pe_bus_pkg;

   localparam int NUM_REGS  = 32;
   localparam int REG_IDX_W = 5;
   localparam int DATA_W    = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY     = 2'd1,
      MEM_WAIT = 2'd2,
      DONE     = 2'd3
   } state_e;

   // x0 always reads zero; a same-cycle write to the read index wins over storage
   function automatic logic [DATA_W-1:0] reg_read(
      input logic [DATA_W-1:0]    stored,
      input logic [REG_IDX_W-1:0] rd_idx,
      input logic                 wr_en,
      input logic [REG_IDX_W-1:0] wr_idx,
      input logic [DATA_W-1:0]    wr_data
   );
      logic [DATA_W-1:0] val;
      if (rd_idx == {REG_IDX_W{1'b0}}) begin
         val = {DATA_W{1'b0}};
      end else if (wr_en && (wr_idx == rd_idx)) begin
         val = wr_data;
      end else begin
         val = stored;
      end
      return val;
   endfunction

endpackage

// File: rtl/pe_bus_responder_arb.sv
// Combinational round-robin arbiter: search starts one above the last granted
// index and wraps, returning a one-hot grant and its encoded index.
module rr_arbiter #(
   parameter int NUM_PE = 4,
   parameter int PTR_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
   input  logic [NUM_PE-1:0] req_i,
   input  logic [PTR_W-1:0]  last_i,
   output logic [NUM_PE-1:0] gnt_o,
   output logic [PTR_W-1:0]  gnt_idx_o
);

   // Scan NUM_PE positions after last_i; the first requester found wins
   always_comb begin
      logic found;
      int   idx;
      gnt_o     = {NUM_PE{1'b0}};
      gnt_idx_o = last_i;
      found     = 1'b0;
      idx       = 0;
      for (int k = 1; k <= NUM_PE; k++) begin
         idx = (int'(last_i) + k) % NUM_PE;
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = PTR_W'(idx);
            found      = 1'b1;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/pe_bus_responder.sv
// Responder end of the PE bus: arbitrates PE requests, owns the shared 32x32
// register file and the word-addressed global memory, and drives the return path.
module pe_bus_responder
   import pe_bus_pkg::*;
#(
   parameter int NUM_PE      = 4,
   parameter int MEM_WORDS   = 256,
   parameter int MEM_LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_PE-1:0]    bus_request,
   output logic [NUM_PE-1:0]    grant,
   output logic                 bus_busy,
   input  logic [31:0]          mem_addressBus,
   input  logic [DATA_W-1:0]    data_Store,
   input  logic [DATA_W-1:0]    result_outBus,
   input  logic [REG_IDX_W-1:0] rs1OutBus,
   input  logic [REG_IDX_W-1:0] rs2OutBus,
   input  logic [REG_IDX_W-1:0] rdOutBus,
   input  logic                 reg_selectBus,
   input  logic                 read_enBus,
   input  logic                 rd_writeBus,
   input  logic                 mem_readBus,
   input  logic                 mem_writeBus,
   output logic [DATA_W-1:0]    AmuxBus,
   output logic [DATA_W-1:0]    BmuxBus,
   output logic                 data_ReadyBus,
   output logic [DATA_W-1:0]    memData,
   output logic                 mem_ackBus
);

   localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam int AW    = $clog2(MEM_WORDS);
   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   state_e             state_q, state_d;
   logic [NUM_PE-1:0]  grant_q, grant_d;
   logic               busy_q, busy_d;
   logic [PTR_W-1:0]   last_q, last_d;
   logic [DATA_W-1:0]  amux_q, amux_d, bmux_q, bmux_d;
   logic               drdy_q, drdy_d;
   logic [DATA_W-1:0]  memdata_q, memdata_d;
   logic               ack_q, ack_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        lat_addr_q, lat_addr_d;
   logic [DATA_W-1:0]  lat_data_q, lat_data_d;
   logic               lat_wr_q, lat_wr_d;

   logic [DATA_W-1:0]  regs_q [NUM_REGS];
   logic [DATA_W-1:0]  mem_q  [MEM_WORDS];

   logic [NUM_PE-1:0]  arb_gnt_s;
   logic [PTR_W-1:0]   arb_idx_s;
   logic               reg_we_s;
   logic               mem_we_s;
   logic               mem_fire_s;
   logic               grant_held_s;
   logic [31:0]        op_addr_s;
   logic [DATA_W-1:0]  op_data_s;
   logic               op_wr_s;
   logic [AW-1:0]      widx_s;
   logic               in_range_s;
   logic [1:0]         addr_unused_s;

   rr_arbiter #(.NUM_PE(NUM_PE), .PTR_W(PTR_W)) u_arb (
      .req_i     (bus_request),
      .last_i    (last_q),
      .gnt_o     (arb_gnt_s),
      .gnt_idx_o (arb_idx_s)
   );

   // With MEM_LATENCY==1 the operation completes straight out of BUSY, so the
   // live bus feeds the memory port there; otherwise the latched copy does.
   assign op_addr_s     = (state_q == BUSY) ? mem_addressBus : lat_addr_q;
   assign op_data_s     = (state_q == BUSY) ? data_Store     : lat_data_q;
   assign op_wr_s       = (state_q == BUSY) ? mem_writeBus   : lat_wr_q;
   assign widx_s        = op_addr_s[AW+1:2];
   assign in_range_s    = ~|op_addr_s[31:AW+2];
   assign addr_unused_s = op_addr_s[1:0];
   assign grant_held_s  = |(bus_request & grant_q);

   // Next-state, grant and return-path logic
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      busy_d     = busy_q;
      last_d     = last_q;
      amux_d     = amux_q;
      bmux_d     = bmux_q;
      drdy_d     = 1'b0;
      memdata_d  = memdata_q;
      ack_d      = 1'b0;
      cnt_d      = cnt_q;
      lat_addr_d = lat_addr_q;
      lat_data_d = lat_data_q;
      lat_wr_d   = lat_wr_q;
      reg_we_s   = 1'b0;
      mem_we_s   = 1'b0;
      mem_fire_s = 1'b0;

      case (state_q)
         IDLE: begin
            if (|bus_request) begin
               grant_d = arb_gnt_s;
               last_d  = arb_idx_s;
               busy_d  = 1'b1;
               state_d = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            reg_we_s = rd_writeBus && (rdOutBus != {REG_IDX_W{1'b0}});
            if (read_enBus) begin
               amux_d = reg_read(regs_q[rs1OutBus], rs1OutBus, reg_we_s, rdOutBus, result_outBus);
               if (reg_selectBus) begin
                  bmux_d = reg_read(regs_q[rs2OutBus], rs2OutBus, reg_we_s, rdOutBus, result_outBus);
               end else begin
                  bmux_d = bmux_q;
               end
               drdy_d = 1'b1;
            end else begin
               drdy_d = 1'b0;
            end
            if (mem_writeBus || mem_readBus) begin
               lat_addr_d = mem_addressBus;
               lat_data_d = data_Store;
               lat_wr_d   = mem_writeBus;
               if (MEM_LATENCY == 1) begin
                  mem_fire_s = 1'b1;
                  state_d    = DONE;
               end else begin
                  cnt_d   = CNT_W'(MEM_LATENCY - 2);
                  state_d = MEM_WAIT;
               end
            end else if (!grant_held_s) begin
               grant_d = {NUM_PE{1'b0}};
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               state_d = BUSY;
            end
         end
         MEM_WAIT: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               mem_fire_s = 1'b1;
               state_d    = DONE;
            end else begin
               cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         DONE: begin
            if (!grant_held_s) begin
               grant_d = {NUM_PE{1'b0}};
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               state_d = BUSY;
            end
         end
         default: begin
            grant_d = {NUM_PE{1'b0}};
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase

      // Out-of-range operations still ack: writes are dropped, loads return 0
      if (mem_fire_s) begin
         ack_d = 1'b1;
         if (op_wr_s) begin
            mem_we_s = in_range_s;
         end else begin
            memdata_d = in_range_s ? mem_q[widx_s] : {DATA_W{1'b0}};
         end
      end else begin
         ack_d = 1'b0;
      end
   end

   // Control and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         grant_q    <= {NUM_PE{1'b0}};
         busy_q     <= 1'b0;
         last_q     <= PTR_W'(NUM_PE - 1);
         amux_q     <= {DATA_W{1'b0}};
         bmux_q     <= {DATA_W{1'b0}};
         drdy_q     <= 1'b0;
         memdata_q  <= {DATA_W{1'b0}};
         ack_q      <= 1'b0;
         cnt_q      <= {CNT_W{1'b0}};
         lat_addr_q <= 32'd0;
         lat_data_q <= {DATA_W{1'b0}};
         lat_wr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         busy_q     <= busy_d;
         last_q     <= last_d;
         amux_q     <= amux_d;
         bmux_q     <= bmux_d;
         drdy_q     <= drdy_d;
         memdata_q  <= memdata_d;
         ack_q      <= ack_d;
         cnt_q      <= cnt_d;
         lat_addr_q <= lat_addr_d;
         lat_data_q <= lat_data_d;
         lat_wr_q   <= lat_wr_d;
      end
   end

   // Register file, cleared on reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= {DATA_W{1'b0}};
         end
      end else if (reg_we_s) begin
         regs_q[rdOutBus] <= result_outBus;
      end
   end

   // Global memory contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[widx_s] <= op_data_s;
      end
   end

   assign grant         = grant_q;
   assign bus_busy      = busy_q;
   assign AmuxBus       = amux_q;
   assign BmuxBus       = bmux_q;
   assign data_ReadyBus = drdy_q;
   assign memData       = memdata_q;
   assign mem_ackBus    = ack_q;

endmodule

// File: tb/tb_pe_bus_responder.sv
// Directed bench for pe_bus_responder: arbitration, register file via a vector
// table, memory timing/range handling and reset abort.
module tb_pe_bus_responder;

   logic        clk;
   logic        reset;
   logic [3:0]  bus_request;
   logic [3:0]  grant;
   logic        bus_busy;
   logic [31:0] mem_addressBus;
   logic [31:0] data_Store;
   logic [31:0] result_outBus;
   logic [4:0]  rs1OutBus, rs2OutBus, rdOutBus;
   logic        reg_selectBus, read_enBus, rd_writeBus, mem_readBus, mem_writeBus;
   logic [31:0] AmuxBus, BmuxBus, memData;
   logic        data_ReadyBus, mem_ackBus;

   int errors = 0;
   int checks = 0;

   pe_bus_responder #(.NUM_PE(4), .MEM_WORDS(256), .MEM_LATENCY(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .bus_request    (bus_request),
      .grant          (grant),
      .bus_busy       (bus_busy),
      .mem_addressBus (mem_addressBus),
      .data_Store     (data_Store),
      .result_outBus  (result_outBus),
      .rs1OutBus      (rs1OutBus),
      .rs2OutBus      (rs2OutBus),
      .rdOutBus       (rdOutBus),
      .reg_selectBus  (reg_selectBus),
      .read_enBus     (read_enBus),
      .rd_writeBus    (rd_writeBus),
      .mem_readBus    (mem_readBus),
      .mem_writeBus   (mem_writeBus),
      .AmuxBus        (AmuxBus),
      .BmuxBus        (BmuxBus),
      .data_ReadyBus  (data_ReadyBus),
      .memData        (memData),
      .mem_ackBus     (mem_ackBus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [4:0]  rd;
      logic [31:0] wdata;
      logic        ren;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        sel;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic        exp_rdy;
   } reg_vec_t;

   reg_vec_t vecs [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered in BUSY one step after an edge; leaves in BUSY after DONE
   task automatic mem_op(input string nm, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic chk_rd, input logic [31:0] exp);
      mem_addressBus = addr;
      data_Store     = data;
      mem_writeBus   = wr;
      mem_readBus    = ~wr;
      tick();
      mem_writeBus = 1'b0;
      mem_readBus  = 1'b0;
      chk({nm, " ack_early"}, 32'(mem_ackBus), 32'd0);
      tick();
      chk({nm, " ack"}, 32'(mem_ackBus), 32'd1);
      if (chk_rd) chk({nm, " memData"}, memData, exp);
      tick();
      chk({nm, " ack_pulse"}, 32'(mem_ackBus), 32'd0);
   endtask

   initial begin
      vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd0,  1'b0, 32'h0,        32'h0,        1'b0};
      vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd0,  1'b1, 32'hDEADBEEF, 32'h0,        1'b1};
      vecs[2] = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  5'd0,  1'b0, 32'hDEADBEEF, 32'h0,        1'b0};
      vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd5,  1'b1, 32'h0,        32'hDEADBEEF, 1'b1};
      vecs[4] = '{1'b1, 5'd7,  32'hCAFEF00D, 1'b1, 5'd7,  5'd7,  1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1};
      vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd0,  1'b0, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1};
      vecs[6] = '{1'b1, 5'd31, 32'h00000001, 1'b1, 5'd31, 5'd0,  1'b0, 32'h00000001, 32'hCAFEF00D, 1'b1};
      vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd31, 1'b1, 32'hCAFEF00D, 32'h00000001, 1'b1};

      reset = 1'b0;
      bus_request = 4'b0000;
      mem_addressBus = 32'd0; data_Store = 32'd0; result_outBus = 32'd0;
      rs1OutBus = 5'd0; rs2OutBus = 5'd0; rdOutBus = 5'd0;
      reg_selectBus = 1'b0; read_enBus = 1'b0; rd_writeBus = 1'b0;
      mem_readBus = 1'b0; mem_writeBus = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();

      chk("rst grant", 32'(grant), 32'd0);
      chk("rst busy", 32'(bus_busy), 32'd0);
      chk("rst amux", AmuxBus, 32'd0);
      chk("rst bmux", BmuxBus, 32'd0);
      chk("rst drdy", 32'(data_ReadyBus), 32'd0);
      chk("rst memData", memData, 32'd0);
      chk("rst ack", 32'(mem_ackBus), 32'd0);

      // Arbitration: PE0 and PE2 together, then hand-over with an idle gap
      bus_request = 4'b0101;
      tick();
      chk("arb pe0 grant", 32'(grant), 32'h1);
      chk("arb pe0 busy", 32'(bus_busy), 32'd1);
      bus_request = 4'b0100;
      tick();
      chk("arb release grant", 32'(grant), 32'h0);
      chk("arb release busy", 32'(bus_busy), 32'd0);
      tick();
      chk("arb pe2 grant", 32'(grant), 32'h4);
      bus_request = 4'b0000;
      tick();
      chk("arb pe2 release", 32'(grant), 32'h0);
      bus_request = 4'b1010;
      tick();
      chk("arb rr pe3", 32'(grant), 32'h8);
      bus_request = 4'b1000;

      // Register file vectors while PE3 holds the bus
      for (int i = 0; i < 8; i++) begin
         rd_writeBus   = vecs[i].wr;
         rdOutBus      = vecs[i].rd;
         result_outBus = vecs[i].wdata;
         read_enBus    = vecs[i].ren;
         rs1OutBus     = vecs[i].rs1;
         rs2OutBus     = vecs[i].rs2;
         reg_selectBus = vecs[i].sel;
         tick();
         rd_writeBus = 1'b0;
         read_enBus  = 1'b0;
         chk($sformatf("vec%0d amux", i), AmuxBus, vecs[i].exp_a);
         chk($sformatf("vec%0d bmux", i), BmuxBus, vecs[i].exp_b);
         chk($sformatf("vec%0d drdy", i), 32'(data_ReadyBus), 32'(vecs[i].exp_rdy));
      end
      tick();
      chk("drdy pulse end", 32'(data_ReadyBus), 32'd0);
      chk("grant held pe3", 32'(grant), 32'h8);

      // Memory timing, range handling and byte-offset masking
      mem_op("wr 0x10", 1'b1, 32'h10, 32'hA5A5A5A5, 1'b0, 32'h0);
      mem_op("rd 0x10", 1'b0, 32'h10, 32'h0, 1'b1, 32'hA5A5A5A5);
      mem_op("rd oor", 1'b0, 32'h10000, 32'h0, 1'b1, 32'h0);
      mem_op("wr oor", 1'b1, 32'h10010, 32'hFFFFFFFF, 1'b0, 32'h0);
      mem_op("rd 0x13", 1'b0, 32'h13, 32'h0, 1'b1, 32'hA5A5A5A5);
      mem_op("wr 0x20", 1'b1, 32'h20, 32'h01234567, 1'b0, 32'h0);
      mem_op("rd 0x20", 1'b0, 32'h20, 32'h0, 1'b1, 32'h01234567);

      // Request dropped during MEM_WAIT: still acks, grant released after DONE
      mem_addressBus = 32'h10;
      mem_readBus    = 1'b1;
      tick();
      mem_readBus = 1'b0;
      bus_request = 4'b0000;
      chk("drop wait grant", 32'(grant), 32'h8);
      tick();
      chk("drop ack", 32'(mem_ackBus), 32'd1);
      chk("drop memData", memData, 32'hA5A5A5A5);
      chk("drop done grant", 32'(grant), 32'h8);
      tick();
      chk("drop release", 32'(grant), 32'h0);

      // Reset asserted in MEM_WAIT aborts the write with no ack
      bus_request = 4'b0010;
      tick();
      chk("pe1 grant", 32'(grant), 32'h2);
      mem_addressBus = 32'h10;
      data_Store     = 32'h11111111;
      mem_writeBus   = 1'b1;
      tick();
      mem_writeBus = 1'b0;
      reset = 1'b0;
      #1;
      chk("abort grant", 32'(grant), 32'h0);
      chk("abort busy", 32'(bus_busy), 32'd0);
      chk("abort ack", 32'(mem_ackBus), 32'd0);
      tick();
      chk("abort ack later", 32'(mem_ackBus), 32'd0);
      chk("abort memData", memData, 32'd0);
      reset = 1'b1;
      tick();
      chk("post rst ack", 32'(mem_ackBus), 32'd0);
      chk("post rst grant pe1", 32'(grant), 32'h2);
      read_enBus = 1'b1; rs1OutBus = 5'd5; reg_selectBus = 1'b1; rs2OutBus = 5'd7;
      tick();
      read_enBus = 1'b0;
      chk("regs cleared a", AmuxBus, 32'd0);
      chk("regs cleared b", BmuxBus, 32'd0);
      mem_op("rd after abort", 1'b0, 32'h10, 32'h0, 1'b1, 32'hA5A5A5A5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
